// File: rtl/writeback_arbiter_if.sv
// Write-back port bundle: ALU result, LSU handshake, register-file write port,
// decode-stage forwarding lookups and queue occupancy.
// master = producer/consumer side (pipeline, testbench); slave = writeback_arbiter.
interface writeback_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;

    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;

    logic [ADDR_W-1:0] fwd_addr1;
    logic [ADDR_W-1:0] fwd_addr2;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;

    logic [2:0]        q_count;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        output fwd_addr1, fwd_addr2,
        input  lsu_ready,
        input  rf_write_enable, rf_write_addr, rf_write_data,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        input  q_count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        input  fwd_addr1, fwd_addr2,
        output lsu_ready,
        output rf_write_enable, rf_write_addr, rf_write_data,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        output q_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: ALU results go straight to the registered write port;
// LSU results are queued in a small FIFO and drained whenever the ALU is idle.
// Optional macro WB_FWD_EN adds combinational forwarding of pending writes
// (output stage and queued entries) to the two decode read addresses.
module writeback_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int QDEPTH = 2        // 1..7 entries
) (
    input  logic               clk,
    input  logic               reset,
    writeback_arbiter_if.slave bus
);
    // Pointer width covers 0..QDEPTH-1; storage is rounded up to a power of
    // two so the pointer indexes it with no width mismatch.
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam logic [2:0]       DEPTH_C  = 3'(QDEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);

    logic [2:0]        count_reg, count_next;
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic              rf_we_reg, rf_we_next;
    logic [ADDR_W-1:0] rf_addr_reg, rf_addr_next;
    logic [DATA_W-1:0] rf_data_reg, rf_data_next;

    logic [ADDR_W-1:0] q_addr [SLOTS];
    logic [DATA_W-1:0] q_data [SLOTS];

    logic ready;
    logic push;
    logic pop;

    // Ready looks only at registered occupancy: a pop in the same cycle never
    // makes room for a push into a full queue.
    assign ready = (count_reg < DEPTH_C);
    assign push  = bus.lsu_valid & ready;
    assign pop   = ~bus.alu_valid & (count_reg != 3'd0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Next-state: ALU beats the queue; otherwise pop head; otherwise idle
    // with address/data held.
    always_comb begin
        count_next   = count_reg;
        head_next    = head_reg;
        tail_next    = tail_reg;
        rf_we_next   = 1'b0;
        rf_addr_next = rf_addr_reg;
        rf_data_next = rf_data_reg;

        if (bus.alu_valid) begin
            rf_we_next   = 1'b1;
            rf_addr_next = bus.alu_addr;
            rf_data_next = bus.alu_data;
        end else if (pop) begin
            rf_we_next   = 1'b1;
            rf_addr_next = q_addr[head_reg];
            rf_data_next = q_data[head_reg];
            head_next    = ptr_inc(head_reg);
        end

        if (push) begin
            tail_next = ptr_inc(tail_reg);
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
    end

    // Control state and output stage; reset discards anything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= 3'd0;
            head_reg    <= '0;
            tail_reg    <= '0;
            rf_we_reg   <= 1'b0;
            rf_addr_reg <= '0;
            rf_data_reg <= '0;
        end else begin
            count_reg   <= count_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            rf_we_reg   <= rf_we_next;
            rf_addr_reg <= rf_addr_next;
            rf_data_reg <= rf_data_next;
        end
    end

    // Queue payload storage; validity is tracked by count/head, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail_reg] <= bus.lsu_addr;
            q_data[tail_reg] <= bus.lsu_data;
        end
    end

    assign bus.lsu_ready       = ready;
    assign bus.q_count         = count_reg;
    assign bus.rf_write_enable = rf_we_reg;
    assign bus.rf_write_addr   = rf_addr_reg;
    assign bus.rf_write_data   = rf_data_reg;

`ifdef WB_FWD_EN
    localparam int SUM_W = PTR_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(QDEPTH);

    // age_slot[k] is the storage slot of the k-th oldest entry; age_valid[k]
    // says whether that entry is currently occupied.
    logic [PTR_W-1:0]  age_slot [QDEPTH];
    logic [QDEPTH-1:0] age_valid;
    logic [ADDR_W-1:0] look_addr [2];

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_age
            logic [SUM_W-1:0] sum;
            assign sum = {1'b0, head_reg} + SUM_W'(gi);
            assign age_slot[gi]  = (sum >= DEPTH_S) ? PTR_W'(sum - DEPTH_S)
                                                    : sum[PTR_W-1:0];
            assign age_valid[gi] = (3'(gi) < count_reg);
        end
    endgenerate

    assign look_addr[0] = bus.fwd_addr1;
    assign look_addr[1] = bus.fwd_addr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic              hit;
            logic [DATA_W-1:0] data;
            // Scan oldest to youngest so the youngest pending write wins;
            // the output stage is the oldest of all.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                if (rf_we_reg && (rf_addr_reg == look_addr[gi])) begin
                    hit  = 1'b1;
                    data = rf_data_reg;
                end
                for (int k = 0; k < QDEPTH; k++) begin
                    if (age_valid[k] && (q_addr[age_slot[k]] == look_addr[gi])) begin
                        hit  = 1'b1;
                        data = q_data[age_slot[k]];
                    end
                end
            end
        end
    endgenerate

    assign bus.fwd_hit1  = g_fwd[0].hit;
    assign bus.fwd_data1 = g_fwd[0].data;
    assign bus.fwd_hit2  = g_fwd[1].hit;
    assign bus.fwd_data2 = g_fwd[1].data;
`else
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data2 = '0;

    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{bus.fwd_addr1, bus.fwd_addr2};
`endif

endmodule
